// File: rtl/queue_8.sv
// 8-entry, 8-bit synchronous FIFO with level-sampled push/pop strobes.
// Full queues reject pushes unless a pop frees a slot on the same edge.
module queue_8 (
  input  logic       clock_10k,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enq_in,
  input  logic       deq_in,
  output logic [7:0] data_out,
  output logic [3:0] len_out,
  output logic       status_out
);

  logic [7:0] mem [0:7];
  logic [2:0] wr;
  logic [2:0] rd;
  logic [3:0] count;
  logic       do_push;
  logic       do_pop;

  // A pop needs stored data; a push needs a free slot, or one freed by this edge's pop.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (deq_in && (count != 4'd0)) begin
      do_pop = 1'b1;
    end
    if (enq_in && ((count != 4'd8) || do_pop)) begin
      do_push = 1'b1;
    end
  end

  always_ff @(posedge clock_10k) begin
    if (!reset) begin
      wr       <= 3'd0;
      rd       <= 3'd0;
      count    <= 4'd0;
      data_out <= 8'h00;
    end else begin
      if (do_push) begin
        wr <= wr + 3'd1;
      end
      if (do_pop) begin
        rd       <= rd + 3'd1;
        data_out <= mem[rd];
      end
      count <= count + {3'b000, do_push} - {3'b000, do_pop};
    end
  end

  // Storage is data only: no reset, written only outside reset.
  always_ff @(posedge clock_10k) begin
    if (reset && do_push) begin
      mem[wr] <= data_in;
    end
  end

  assign len_out    = count;
  assign status_out = count[3];

endmodule

// File: tb/tb_queue_8.sv
// Randomized and directed bench for queue_8 against a queue-based reference model.
module tb_queue_8;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       enq_in;
  logic       deq_in;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       status_out;

  int n_checks;
  int n_fail;
  bit chk_en;

  logic [7:0] model_q[$];
  logic [7:0] model_data;

  queue_8 dut (
    .clock_10k (clk),
    .reset     (reset),
    .data_in   (data_in),
    .enq_in    (enq_in),
    .deq_in    (deq_in),
    .data_out  (data_out),
    .len_out   (len_out),
    .status_out(status_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", data_out, model_data);
      check("len_out", {4'h0, len_out}, 8'(model_q.size()));
      check("status_out", {7'h0, status_out}, {7'h0, (model_q.size() == 8)});
    end
  end

  // One clock: apply inputs, step the model on the edge, return at the falling edge.
  task automatic op(input logic r, input logic e, input logic d, input logic [7:0] din);
    bit pop;
    bit push;
    reset   = r;
    enq_in  = e;
    deq_in  = d;
    data_in = din;
    @(posedge clk);
    if (!r) begin
      model_q.delete();
      model_data = 8'h00;
    end else begin
      pop  = d && (model_q.size() > 0);
      push = e && ((model_q.size() < 8) || pop);
      if (pop) model_data = model_q.pop_front();
      if (push) model_q.push_back(din);
    end
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] fill_vals [0:8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
  logic [7:0] wrap_vals [0:6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h10};
  logic [7:0] drain_exp [0:7] = '{8'h66, 8'h77, 8'h88, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    chk_en     = 1'b0;
    model_data = 8'h00;
    reset      = 1'b0;
    enq_in     = 1'b0;
    deq_in     = 1'b0;
    data_in    = 8'h00;
    @(negedge clk);

    // Reset held with a push request: nothing gets stored.
    op(1'b0, 1'b1, 1'b0, 8'h5C);
    op(1'b0, 1'b1, 1'b0, 8'h5C);
    check("rst_len", {4'h0, len_out}, 8'd0);
    check("rst_status", {7'h0, status_out}, 8'd0);
    check("rst_data", data_out, 8'h00);
    op(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_nothing_stored", {4'h0, len_out}, 8'd0);

    // Fill and overflow.
    for (int i = 0; i < 9; i++) begin
      op(1'b1, 1'b1, 1'b0, fill_vals[i]);
      if (i < 8) check("fill_len", {4'h0, len_out}, 8'(i + 1));
    end
    check("overflow_len", {4'h0, len_out}, 8'd8);
    check("overflow_status", {7'h0, status_out}, 8'd1);

    // Partial drain.
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, 1'b1, 8'h00);
      check("drain_data", data_out, fill_vals[i]);
    end
    check("drain_len", {4'h0, len_out}, 8'd3);
    check("drain_status", {7'h0, status_out}, 8'd0);

    // Wrap-around with rejected overflow.
    for (int i = 0; i < 7; i++) begin
      op(1'b1, 1'b1, 1'b0, wrap_vals[i]);
      if (i == 4) check("wrap_full_len", {4'h0, len_out}, 8'd8);
    end
    check("wrap_reject_len", {4'h0, len_out}, 8'd8);
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 1'b0, 1'b1, 8'h00);
      check("wrap_drain_data", data_out, drain_exp[i]);
    end

    // Underflow holds the last byte.
    op(1'b1, 1'b0, 1'b1, 8'h00);
    check("underflow_len", {4'h0, len_out}, 8'd0);
    check("underflow_data", data_out, 8'hEE);

    // Simultaneous strobes on empty, then on full.
    op(1'b1, 1'b1, 1'b1, 8'h5A);
    check("simul_empty_len", {4'h0, len_out}, 8'd1);
    check("simul_empty_data", data_out, 8'hEE);
    for (int i = 1; i < 8; i++) op(1'b1, 1'b1, 1'b0, 8'(i));
    check("simul_pre_full", {7'h0, status_out}, 8'd1);
    op(1'b1, 1'b1, 1'b1, 8'hC3);
    check("simul_full_data", data_out, 8'h5A);
    check("simul_full_len", {4'h0, len_out}, 8'd8);
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 1'b1, 8'h00);
    check("simul_full_last", data_out, 8'hC3);

    // Random traffic with occasional resets, alternating fill/drain bias.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic e;
      logic d;
      int bias;
      bias = ((i / 200) % 2 == 0) ? 75 : 25;
      r = ($urandom_range(0, 149) != 0);
      e = ($urandom_range(0, 99) < bias);
      d = ($urandom_range(0, 99) >= bias);
      if ($urandom_range(0, 7) == 0) begin
        e = 1'b1;
        d = 1'b1;
      end
      op(r, e, d, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_8.md
# queue_8

8-deep, 8-bit-wide synchronous FIFO queue with single-cycle enqueue and dequeue strobes. It buffers deserialized bytes between the producer and downstream consumer logic in the deserializer datapath. It reports current occupancy (`len_out`) and a full flag (`status_out`). Overflow is rejected: a full queue never overwrites stored data.

## Interface
- No parameters. Data width is fixed at 8 bits, depth at 8 entries, `len_out` at 4 bits.
- One clock; reset is synchronous and active-low.
- `clock_10k`  in  1  system clock (10 kHz); all state changes on its rising edge.
- `reset`  in  1  synchronous active-low reset, sampled on the rising edge of `clock_10k`.
- `data_in`  in  8  byte to enqueue; sampled when `enq_in`=1.
- `enq_in`  in  1  enqueue request, level-sampled each rising edge (one push per high cycle).
- `deq_in`  in  1  dequeue request, level-sampled each rising edge (one pop per high cycle).
- `data_out`  out  8  last dequeued byte, registered.
- `len_out`  out  4  number of stored entries, 0..8, registered.
- `status_out`  out  1  full flag: 1 when `len_out`==8, registered.

## Operation
- Storage: 8×8 register array, 3-bit write pointer `wr`, 3-bit read pointer `rd`, 4-bit count. Both pointers wrap modulo 8 (7→0).
- Reset (`reset`=0 at a rising edge):
  - `wr`, `rd` and count go to 0.
  - `data_out`=8'h00, `len_out`=0, `status_out`=0.
  - Array contents are don't-care.
  - Reset overrides `enq_in` and `deq_in` in the same cycle.
  - Asserting reset mid-operation discards all queued data.
- Enqueue only (`enq_in`=1, `deq_in`=0):
  - Count < 8: write `data_in` to `mem[wr]`, increment `wr` and count.
  - Count == 8: ignore the request. Storage, pointers and count are unchanged; nothing is overwritten.
- Dequeue only (`deq_in`=1, `enq_in`=0):
  - Count > 0: `data_out` <= `mem[rd]`, increment `rd`, decrement count.
  - Count == 0: ignore the request; `data_out` holds its value.
- Simultaneous `enq_in`=1 and `deq_in`=1:
  - Count == 0: enqueue only (count becomes 1, `data_out` unchanged).
  - Count 1..8: pop and push in the same edge. `data_out` <= `mem[rd]`, `mem[wr]` <= `data_in`, both pointers advance, count unchanged.
  - At count == 8 the push is therefore accepted because a slot is freed in the same cycle.
- Idle (both strobes 0): all state holds. `data_out` keeps the last dequeued byte indefinitely.
- `len_out` = count. `status_out` = (count == 8). Both are driven from registers or from the count register directly; no combinational path from any input.

## Timing
- Every output changes only on a rising edge of `clock_10k`, one cycle after the sampled request (latency 1).
- A strobe held high for N cycles performs N operations.
- An enqueued byte may be dequeued on the very next edge. No bypass: dequeuing an empty queue never returns the `data_in` of the same cycle.
- `status_out` rises on the edge that makes count 8 and falls on the first edge that performs a net pop.
- Ordering is strict FIFO across pointer wrap-around.

## Test plan
- **Reset:** hold `reset`=0 for 2 edges with `enq_in`=1 -> `len_out`=0, `status_out`=0, `data_out`=00; no entry is stored.
- **Fill and overflow:** from empty, enqueue 11,22,33,44,55,66,77,88,99 on separate strobe cycles.
  - `len_out` steps 1..8; `status_out`=1 after 88.
  - The 99 push is ignored: `len_out` stays 8.
- **Drain partly:** 5 single-cycle dequeues -> `data_out` = 11,22,33,44,55 in order; `len_out` = 3; `status_out`=0.
- **Wrap and no overwrite:** enqueue AA,BB,CC,DD,EE,FF,10.
  - `len_out` reaches 8 after EE; FF and 10 are rejected.
  - 8 dequeues then yield 66,77,88,AA,BB,CC,DD,EE.
- **Empty underflow:** dequeue on empty queue -> `len_out` stays 0; `data_out` holds EE.
- **Simultaneous strobes:**
  - Empty queue, enq+deq with 5A -> `len_out`=1, `data_out` unchanged.
  - Full queue, enq+deq -> oldest byte appears on `data_out`, `len_out` stays 8, and the new byte is dequeued last.
